// File: rtl/pp_row_streamer.sv
// Handshaked partial-product row streamer for a Dadda reduction tree.
// Emits ROWS_PER_BEAT unshifted rows per beat, with optional Baugh-Wooley signed rows.

module pp_row_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    input  logic             sgn,
    input  logic             top_row,
    output logic [WIDTH-1:0] row
);
    // Signed mode flips bits where exactly one of (row, column) is the MSB position.
    always_comb begin
        row = '0;
        for (int j = 0; j < WIDTH; j++)
            row[j] = (a[j] & b_bit) ^ (sgn & (top_row ^ (j == WIDTH - 1)));
    end
endmodule

module pp_row_streamer #(
    parameter int WIDTH         = 16,
    parameter int ROWS_PER_BEAT = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_a,
    input  logic [WIDTH-1:0]                 in_b,
    input  logic                             in_signed,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROWS_PER_BEAT*WIDTH-1:0]   out_rows,
    output logic [$clog2(WIDTH)-1:0]         out_row_idx,
    output logic                             out_last,
    output logic                             out_corr
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WIDTH - ROWS_PER_BEAT);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(ROWS_PER_BEAT);
    localparam logic [IDX_W-1:0] TOP_ROW  = IDX_W'(WIDTH - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IDX_W-1:0] cnt;
    logic             load, accept, last;
    logic [ROWS_PER_BEAT-1:0][WIDTH-1:0] rows;

    assign last = (state == EMIT) && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                load     = in_valid & in_ready;
                if (load) state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                accept    = out_ready;
                // A new pair can only slip in on the edge that retires the last beat.
                in_ready  = ~rst & out_ready & last;
                load      = in_valid & in_ready;
                if (accept && last && !load) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sgn_q <= in_signed;
            cnt   <= '0;
        end else if (accept) begin
            cnt   <= cnt + STEP;
        end
    end

    for (genvar k = 0; k < ROWS_PER_BEAT; k++) begin : g_row
        logic [IDX_W-1:0] ri;
        assign ri = cnt + IDX_W'(k);
        pp_row_gen #(.WIDTH(WIDTH)) u_row (
            .a       (a_q),
            .b_bit   (b_q[ri]),
            .sgn     (sgn_q),
            .top_row (ri == TOP_ROW),
            .row     (rows[k])
        );
    end

    assign out_rows    = out_valid ? rows : '0;
    assign out_row_idx = out_valid ? cnt : '0;
    assign out_last    = last;
    assign out_corr    = sgn_q & last;
endmodule
